recfn_to_fp32: RTL and testbench

Sequential decoder from the recoded single-precision format back to IEEE-754 binary32. It is the inverse of `torecFN` and sits on the FPU result path, after recoded-domain arithmetic and before register writeback. Each transaction is accepted with a valid/ready handshake. Subnormal results are denormalized by an iterative right shifter, so their latency depends on the data. Each result is held until the consumer accepts it.

---
 rtl/recfn_to_fp32_if.sv | 29 ++
 rtl/recfn_to_fp32.sv | 83 ++++++++
 tb/tb_recfn_to_fp32.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/recfn_to_fp32_if.sv
// recfn_to_fp32_if: handshake bundle between a recoded-operand producer and the binary32 decoder
// Producer side (master) drives the recoded operand, its class flags and out_ready.
// Decoder side (slave) returns in_ready, out_valid, out_fp and out_invalid.
interface recfn_to_fp32_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [23:0] in_sig;
  logic        in_isNAN;
  logic        in_isINf;
  logic        in_isZero;
  logic        in_isNormalize;
  logic        in_isUnormalize;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic        out_invalid;
  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_isNAN, in_isINf, in_isZero,
           in_isNormalize, in_isUnormalize, out_ready,
    input  in_ready, out_valid, out_fp, out_invalid
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_isNAN, in_isINf, in_isZero,
           in_isNormalize, in_isUnormalize, out_ready,
    output in_ready, out_valid, out_fp, out_invalid
  );
endinterface

// File: rtl/recfn_to_fp32.sv
// recfn_to_fp32: recoded binary32 to IEEE binary32 decoder with an iterative subnormal shifter
// Ports: clk; rst_n (async, active-low); bus (slave): recoded operand in with valid/ready,
// binary32 result out with valid/ready plus an invalid flag. STEP = bits shifted per SHIFT cycle.
module recfn_to_fp32 #(
  parameter int STEP = 1
) (
  input logic             clk,
  input logic             rst_n,
  recfn_to_fp32_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam logic [4:0] STEP5 = 5'(STEP);
  state_t      state_q, state_d;
  logic        sign_q, sign_d, inv_q, inv_d;
  logic [23:0] sig_q, sig_d;
  logic [4:0]  rem_q, rem_d, amt, shift_n;
  logic [31:0] fp_q, fp_d;
  logic [7:0]  exp_m;
  logic        unorm_ok, norm_hi, norm_lo, go_shift;
  logic [32:0] dec;
  assign unorm_ok = bus.in_exp >= 9'h06B && bus.in_exp <= 9'h081;
  assign norm_hi  = bus.in_exp > 9'h17F;
  assign norm_lo  = bus.in_exp < 9'h082;
  // Low 8 bits of (exp - 0x81) and of (0x82 - exp) only need the low operand bits.
  assign exp_m    = bus.in_exp[7:0] - 8'h81;
  assign shift_n  = 5'd2 - bus.in_exp[4:0];
  assign go_shift = !bus.in_isNAN && !bus.in_isINf && !bus.in_isZero && bus.in_isUnormalize && unorm_ok;
  assign amt      = rem_q < STEP5 ? rem_q : STEP5;
  // {invalid, fp} for everything resolved at accept; the Unormalize arm is only used when illegal.
  always_comb
    dec = bus.in_isNAN        ? {1'b0, bus.in_sign, 8'hFF, 1'b1, bus.in_sig[21:0]} :
          bus.in_isINf        ? {1'b0, bus.in_sign, 8'hFF, 23'd0} :
          bus.in_isZero       ? {1'b0, bus.in_sign, 31'd0} :
          bus.in_isUnormalize ? {1'b1, bus.in_sign, 31'd0} :
          bus.in_isNormalize  ? (norm_hi ? {1'b1, bus.in_sign, 8'hFF, 23'd0} :
                                 norm_lo ? {1'b1, bus.in_sign, 31'd0} :
                                           {1'b0, bus.in_sign, exp_m, bus.in_sig[22:0]}) :
                                {1'b1, 32'h7FC00000};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      inv_q   <= 1'b0;
      sig_q   <= '0;
      rem_q   <= '0;
      fp_q    <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      inv_q   <= inv_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
      fp_q    <= fp_d;
    end
  always_comb
    state_d = state_q == IDLE  ? (bus.in_valid ? (go_shift ? SHIFT : HOLD) : IDLE) :
              state_q == SHIFT ? (rem_d == 5'd0 ? HOLD : SHIFT) :
                                 (bus.out_ready ? IDLE : HOLD);
  // Result registers only load at the edge entering HOLD, so they stay steady while out_valid is high.
  always_comb begin
    sign_d = sign_q;
    sig_d  = sig_q;
    rem_d  = rem_q;
    fp_d   = fp_q;
    inv_d  = inv_q;
    if (state_q == IDLE && bus.in_valid) begin
      sign_d        = bus.in_sign;
      sig_d         = bus.in_sig;
      rem_d         = shift_n;
      {inv_d, fp_d} = go_shift ? {inv_q, fp_q} : dec;
    end else if (state_q == SHIFT) begin
      sig_d = sig_q >> amt;
      rem_d = rem_q - amt;
      if (rem_d == 5'd0) {inv_d, fp_d} = {1'b0, sign_q, 8'h00, sig_d[22:0]};
    end
  end
  always_comb begin
    bus.in_ready    = state_q == IDLE;
    bus.out_valid   = state_q == HOLD;
    bus.out_fp      = fp_q;
    bus.out_invalid = inv_q;
  end
endmodule

// File: tb/tb_recfn_to_fp32.sv
// tb_recfn_to_fp32: checks the decoder with STEP=1 and STEP=8 instances driven in lockstep
module tb_recfn_to_fp32;
  typedef struct {
    logic        s;
    logic [8:0]  e;
    logic [23:0] g;
    logic [4:0]  f;   // {nan, inf, zero, unorm, norm}
    logic [31:0] fp;
    logic        inv;
    int          l1;
    int          l8;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_sign = 0, out_ready = 0;
  logic [8:0]  in_exp = 0;
  logic [23:0] in_sig = 0;
  logic [4:0]  in_f = 0;
  int tests = 0, fails = 0;
  vec_t tbl[$];
  recfn_to_fp32_if b1();
  recfn_to_fp32_if b8();
  recfn_to_fp32 #(.STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  recfn_to_fp32 #(.STEP(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  always #5 clk = ~clk;
  assign b1.in_valid = in_valid;           assign b8.in_valid = in_valid;
  assign b1.in_sign = in_sign;             assign b8.in_sign = in_sign;
  assign b1.in_exp = in_exp;               assign b8.in_exp = in_exp;
  assign b1.in_sig = in_sig;               assign b8.in_sig = in_sig;
  assign b1.in_isNAN = in_f[4];            assign b8.in_isNAN = in_f[4];
  assign b1.in_isINf = in_f[3];            assign b8.in_isINf = in_f[3];
  assign b1.in_isZero = in_f[2];           assign b8.in_isZero = in_f[2];
  assign b1.in_isUnormalize = in_f[1];     assign b8.in_isUnormalize = in_f[1];
  assign b1.in_isNormalize = in_f[0];      assign b8.in_isNormalize = in_f[0];
  assign b1.out_ready = out_ready;         assign b8.out_ready = out_ready;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // Reference: {invalid, fp} straight from the class/exponent rules using integer arithmetic.
  function automatic logic [32:0] model(input logic s, input logic [8:0] e, input logic [23:0] g, input logic [4:0] f);
    int ei, fr, ex;
    ei = e;
    if (f[4]) return {1'b0, s, 8'hFF, 1'b1, g[21:0]};
    if (f[3]) return {1'b0, s, 8'hFF, 23'd0};
    if (f[2]) return {1'b0, s, 31'd0};
    if (f[1]) begin
      if (ei < 'h6B || ei > 'h81) return {1'b1, s, 31'd0};
      fr = int'(g) / (1 << ('h82 - ei));
      return {1'b0, s, 8'h00, fr[22:0]};
    end
    if (f[0]) begin
      if (ei > 'h17F) return {1'b1, s, 8'hFF, 23'd0};
      if (ei < 'h82) return {1'b1, s, 31'd0};
      ex = ei - 'h81;
      return {1'b0, s, ex[7:0], g[22:0]};
    end
    return {1'b1, 32'h7FC00000};
  endfunction
  function automatic int lat(input logic [8:0] e, input logic [4:0] f, input int step);
    int ei;
    ei = e;
    if (f[4:2] == 0 && f[1] && ei >= 'h6B && ei <= 'h81) return 1 + ('h82 - ei + step - 1) / step;
    return 1;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int c1, c8;
    c1 = 0;
    c8 = 0;
    @(negedge clk);
    check({tag, " in_ready"}, {b1.in_ready, b8.in_ready}, 2'b11);
    in_sign = v.s; in_exp = v.e; in_sig = v.g; in_f = v.f; in_valid = 1;
    for (int i = 1; i <= 40 && (c1 == 0 || c8 == 0); i++) begin
      @(posedge clk);
      #1 in_valid = 0;
      if (c1 == 0 && b1.out_valid) c1 = i;
      if (c8 == 0 && b8.out_valid) c8 = i;
    end
    check({tag, " lat1"}, c1, v.l1);
    check({tag, " lat8"}, c8, v.l8);
    check({tag, " fp1"}, b1.out_fp, v.fp);
    check({tag, " fp8"}, b8.out_fp, v.fp);
    check({tag, " inv"}, {b1.out_invalid, b8.out_invalid}, {v.inv, v.inv});
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check({tag, " release"}, {b1.out_valid, b8.out_valid, b1.in_ready, b8.in_ready}, 4'b0011);
  endtask
  initial begin
    vec_t v;
    logic [32:0] m;
    int seen;
    tbl.push_back('{1'b0, 9'h100, 24'h800000, 5'b00001, 32'h3F800000, 1'b0, 1, 1});
    tbl.push_back('{1'b0, 9'h000, 24'h000000, 5'b10000, 32'h7FC00000, 1'b0, 1, 1});
    tbl.push_back('{1'b1, 9'h000, 24'h000000, 5'b01000, 32'hFF800000, 1'b0, 1, 1});
    tbl.push_back('{1'b1, 9'h000, 24'h000000, 5'b00100, 32'h80000000, 1'b0, 1, 1});
    tbl.push_back('{1'b0, 9'h000, 24'h000123, 5'b11000, 32'h7FC00123, 1'b0, 1, 1});
    tbl.push_back('{1'b0, 9'h06B, 24'h800000, 5'b00010, 32'h00000001, 1'b0, 24, 4});
    tbl.push_back('{1'b0, 9'h081, 24'hFFFFFE, 5'b00010, 32'h007FFFFF, 1'b0, 2, 2});
    tbl.push_back('{1'b0, 9'h07A, 24'hABCD00, 5'b00011, 32'h0000ABCD, 1'b0, 9, 2});
    tbl.push_back('{1'b0, 9'h1A0, 24'h800000, 5'b00001, 32'h7F800000, 1'b1, 1, 1});
    tbl.push_back('{1'b1, 9'h050, 24'h800000, 5'b00001, 32'h80000000, 1'b1, 1, 1});
    tbl.push_back('{1'b0, 9'h100, 24'h800000, 5'b00000, 32'h7FC00000, 1'b1, 1, 1});
    tbl.push_back('{1'b1, 9'h06A, 24'h800000, 5'b00010, 32'h80000000, 1'b1, 1, 1});
    tbl.push_back('{1'b0, 9'h082, 24'h800000, 5'b00010, 32'h00000000, 1'b1, 1, 1});
    tbl.push_back('{1'b0, 9'h082, 24'hC00000, 5'b00001, 32'h00C00000, 1'b0, 1, 1});
    tbl.push_back('{1'b1, 9'h17F, 24'h800000, 5'b00001, 32'hFF000000, 1'b0, 1, 1});
    tbl.push_back('{1'b0, 9'h180, 24'h800000, 5'b00001, 32'h7F800000, 1'b1, 1, 1});
    tbl.push_back('{1'b0, 9'h070, 24'h800000, 5'b00110, 32'h00000000, 1'b0, 1, 1});
    #3;
    check("reset outputs", {b1.out_valid, b1.out_fp, b1.out_invalid, b8.out_valid, b8.out_fp, b8.out_invalid}, 0);
    check("reset in_ready", {b1.in_ready, b8.in_ready}, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 150; i++) begin
      v.s = 1'($urandom);
      v.f = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      v.e = ($urandom_range(0, 1) == 0) ? 9'($urandom_range('h60, 'h90)) : 9'($urandom);
      v.g = {1'b1, 23'($urandom)};
      m = model(v.s, v.e, v.g, v.f);
      v.inv = m[32];
      v.fp = m[31:0];
      v.l1 = lat(v.e, v.f, 1);
      v.l8 = lat(v.e, v.f, 8);
      run(v, $sformatf("rnd%0d", i));
    end
    // Backpressure: result must hold and a new in_valid must be ignored while in HOLD.
    @(negedge clk);
    in_sign = 0; in_exp = 9'h100; in_sig = 24'h800000; in_f = 5'b00001; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; in_exp = 9'h101; in_sig = 24'hC00000;
      check($sformatf("bp hold%0d", i), {b1.out_valid, b1.in_ready, b1.out_fp, b8.out_fp}, {2'b10, 32'h3F800000, 32'h3F800000});
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("bp release", {b1.out_valid, b1.in_ready, b8.out_valid, b8.in_ready}, 4'b0101);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (b1.out_valid || b8.out_valid) seen++;
    end
    check("bp no ghost", seen, 0);
    // Reset in the middle of a 23-bit shift aborts the transaction.
    @(negedge clk);
    in_exp = 9'h06B; in_sig = 24'h800000; in_f = 5'b00010; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    in_valid = 1; in_exp = 9'h100; in_f = 5'b00001;
    #1 check("rst mid outputs", {b1.out_valid, b1.out_fp, b1.out_invalid, b8.out_valid, b8.out_fp, b8.out_invalid}, 0);
    check("rst mid in_ready", {b1.in_ready, b8.in_ready}, 2'b11);
    repeat (2) @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (b1.out_valid || b8.out_valid) seen++;
    end
    check("rst no pulse", seen, 0);
    run(tbl[0], "post reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
